// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, opcodes, ALU_op codes and trap causes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_controller_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign cycle_count   = r_cycle;
  assign instret_count = r_instret;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the RISC-V datapath: fetch/decode/exec/mem/wb
// with memory handshakes, wait timeouts, halt, sticky trap and perf counters.
//
// state  | meaning
// FETCH  | request instruction, latch opcode on imem_ready
// DECODE | check opcode legality
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory access until dmem_ready
// WB     | register file write-back, retire
// HALT   | idle until halt_req drops
// TRAP   | sticky error, left only by rst
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       ALU_op,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  logic [6:0]        r_opcode;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_trap_cause;

  logic [WAIT_W-1:0] w_wait_next;
  logic              w_wait_expired;
  logic              w_fetch_halt;
  logic              w_retire;
  logic [1:0]        w_alu_op;
  logic              w_alu_src;
  logic              w_unused;

  assign w_unused       = ^instruction[31:7];
  assign w_wait_next    = r_wait_cnt + WAIT_W'(1);
  assign w_wait_expired = (w_wait_next == WAIT_LIMIT);
  // A zero wait count in FETCH marks its first cycle, the only point a halt is taken.
  assign w_fetch_halt   = (r_state == S_FETCH) && halt_req && (r_wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_opcode     <= '0;
      r_wait_cnt   <= '0;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_halt) begin
            r_state <= S_HALT;
          end else if (imem_ready) begin
            r_opcode <= instruction[6:0];
            r_state  <= S_DECODE;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_IMEM;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_DECODE: begin
          if (is_legal(r_opcode)) begin
            r_state <= S_EXEC;
          end else begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          r_wait_cnt <= '0;
          if (r_opcode == OP_BRANCH) r_state <= S_FETCH;
          else if (r_opcode == OP_LOAD || r_opcode == OP_STORE) r_state <= S_MEM;
          else r_state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_wait_cnt <= '0;
            r_state    <= (r_opcode == OP_LOAD) ? S_WB : S_FETCH;
          end else if (w_wait_expired) begin
            r_state      <= S_TRAP;
            r_trap_cause <= CAUSE_DMEM;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        S_WB: begin
          r_wait_cnt <= '0;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          if (!halt_req) begin
            r_wait_cnt <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b0;
    case (r_opcode)
      OP_R:              w_alu_op = ALU_FUNCT;
      OP_I:              begin w_alu_op = ALU_FUNCT; w_alu_src = 1'b1; end
      OP_LOAD, OP_STORE: w_alu_src = 1'b1;
      OP_BRANCH:         w_alu_op = ALU_SUB;
      default:           ;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_reg   = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    ALU_op    = ALU_ADD;
    halted    = 1'b0;
    trap      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!w_fetch_halt) begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
      end
      S_EXEC: begin
        ALU_op  = w_alu_op;
        alu_src = w_alu_src;
        branch  = (r_opcode == OP_BRANCH);
      end
      S_MEM: begin
        ALU_op    = ALU_ADD;
        alu_src   = 1'b1;
        mem_read  = (r_opcode == OP_LOAD);
        mem_write = (r_opcode == OP_STORE);
      end
      S_WB: begin
        ALU_op    = w_alu_op;
        alu_src   = w_alu_src;
        reg_write = 1'b1;
        mem_reg   = (r_opcode == OP_LOAD);
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: ;
    endcase
    if (rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_reg   = 1'b0;
      alu_src   = 1'b0;
      reg_write = 1'b0;
      ALU_op    = ALU_ADD;
      halted    = 1'b0;
      trap      = 1'b0;
    end
  end

  assign trap_cause = rst ? CAUSE_NONE : r_trap_cause;

  assign w_retire = !rst &&
                    (((r_state == S_EXEC) && (r_opcode == OP_BRANCH)) ||
                     ((r_state == S_MEM) && (r_opcode == OP_STORE) && dmem_ready) ||
                     (r_state == S_WB));

  perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .retire       (w_retire),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: each stimulus cycle
// queues the expected command vector and counters; a monitor compares them.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req, ir_write, pc_write, branch, mem_read, mem_write;
  logic        mem_reg, alu_src, reg_write, halted, trap;
  logic [1:0]  ALU_op, trap_cause;
  logic [31:0] cycle_count, instret_count;

  multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_reg(mem_reg), .alu_src(alu_src), .reg_write(reg_write),
    .ALU_op(ALU_op), .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  // Vector: imem_req ir_write pc_write branch | mem_read mem_write mem_reg alu_src |
  //         reg_write ALU_op[1:0] halted | trap trap_cause[1:0]
  localparam logic [14:0] C_NONE  = 15'h0000;
  localparam logic [14:0] C_FWAIT = 15'h4000;
  localparam logic [14:0] C_FOK   = 15'h7000;
  localparam logic [14:0] C_EXR   = 15'h0020;
  localparam logic [14:0] C_EXI   = 15'h00A0;
  localparam logic [14:0] C_EXLS  = 15'h0080;
  localparam logic [14:0] C_EXBR  = 15'h0810;
  localparam logic [14:0] C_MEMRD = 15'h0480;
  localparam logic [14:0] C_MEMWR = 15'h0280;
  localparam logic [14:0] C_WBR   = 15'h0060;
  localparam logic [14:0] C_WBI   = 15'h00E0;
  localparam logic [14:0] C_WBLD  = 15'h01C0;
  localparam logic [14:0] C_HALT  = 15'h0008;
  localparam logic [14:0] C_T1    = 15'h0005;
  localparam logic [14:0] C_T2    = 15'h0006;
  localparam logic [14:0] C_T3    = 15'h0007;

  localparam logic [31:0] I_R    = 32'h002081B3;
  localparam logic [31:0] I_LD   = 32'h00803283;
  localparam logic [31:0] I_ST   = 32'h00503823;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct {
    string       name;
    logic [14:0] ctl;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_cyc = 0;
  int   m_ret = 0;
  bit   m_prev_rst = 1'b1;
  bit   m_prev_ret = 1'b0;

  initial begin : monitor
    exp_t        e;
    logic [14:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {imem_req, ir_write, pc_write, branch, mem_read, mem_write,
               mem_reg, alu_src, reg_write, ALU_op, halted, trap, trap_cause};
        n_checks++;
        if (got !== e.ctl || cycle_count !== e.cyc || instret_count !== e.ret) begin
          n_fail++;
          $display("FAIL %s: got ctl=%h cyc=%0d ret=%0d, expected ctl=%h cyc=%0d ret=%0d",
                   e.name, got, cycle_count, instret_count, e.ctl, e.cyc, e.ret);
        end
      end
    end
  end

  // One clock of stimulus; ret marks a cycle whose closing edge retires.
  task automatic step(input string nm, input bit r, input logic [31:0] ins,
                      input bit ir, input bit dr, input bit hr,
                      input logic [14:0] ctl, input bit ret);
    exp_t e;
    @(posedge clk);
    #1;
    if (m_prev_rst) begin
      m_cyc = 0;
      m_ret = 0;
    end else begin
      m_cyc++;
      if (m_prev_ret) m_ret++;
    end
    rst = r; instruction = ins; imem_ready = ir; dmem_ready = dr; halt_req = hr;
    e.name = nm; e.ctl = ctl; e.cyc = m_cyc; e.ret = m_ret;
    q.push_back(e);
    m_prev_rst = r;
    m_prev_ret = ret;
  endtask

  initial begin : stimulus
    for (int i = 0; i < 2; i++) step("reset", 1, 0, 0, 0, 0, C_NONE, 0);

    step("r_fetch",  0, I_R, 1, 0, 0, C_FOK,  0);
    step("r_decode", 0, I_R, 1, 0, 0, C_NONE, 0);
    step("r_exec",   0, I_R, 1, 0, 0, C_EXR,  0);
    step("r_wb",     0, I_R, 1, 0, 0, C_WBR,  1);

    step("ld_fetch",  0, I_LD, 1, 0, 0, C_FOK,  0);
    step("ld_decode", 0, I_LD, 0, 0, 0, C_NONE, 0);
    step("ld_exec",   0, I_LD, 0, 0, 0, C_EXLS, 0);
    for (int i = 0; i < 3; i++) step("ld_mem_wait", 0, I_LD, 0, 0, 0, C_MEMRD, 0);
    step("ld_mem_rdy", 0, I_LD, 0, 1, 0, C_MEMRD, 0);
    step("ld_wb",      0, I_LD, 0, 0, 0, C_WBLD,  1);

    step("st_fetch",  0, I_ST, 1, 0, 0, C_FOK,   0);
    step("st_decode", 0, I_ST, 0, 0, 0, C_NONE,  0);
    step("st_exec",   0, I_ST, 0, 0, 0, C_EXLS,  0);
    step("st_mem",    0, I_ST, 0, 1, 0, C_MEMWR, 1);
    step("beq_fetch",  0, I_BEQ, 1, 0, 0, C_FOK,  0);
    step("beq_decode", 0, I_BEQ, 0, 0, 0, C_NONE, 0);
    step("beq_exec",   0, I_BEQ, 0, 0, 0, C_EXBR, 1);

    step("addi_fetch",  0, I_ADDI, 1, 0, 0, C_FOK,  0);
    step("addi_decode", 0, I_ADDI, 0, 0, 0, C_NONE, 0);
    step("addi_exec",   0, I_ADDI, 0, 0, 0, C_EXI,  0);
    step("addi_wb",     0, I_ADDI, 0, 0, 0, C_WBI,  1);

    step("h_fetch",      0, I_LD, 1, 0, 0, C_FOK,   0);
    step("h_decode",     0, I_LD, 0, 0, 1, C_NONE,  0);
    step("h_exec",       0, I_LD, 0, 0, 1, C_EXLS,  0);
    step("h_mem",        0, I_LD, 0, 1, 1, C_MEMRD, 0);
    step("h_wb",         0, I_LD, 0, 0, 1, C_WBLD,  1);
    step("h_fetch_stop", 0, I_LD, 0, 0, 1, C_NONE,  0);
    step("h_halted",     0, I_R,  1, 0, 1, C_HALT,  0);
    step("h_release",    0, I_R,  1, 0, 0, C_HALT,  0);
    step("h_resume",     0, I_R,  1, 0, 0, C_FOK,   0);
    step("h_r_decode",   0, I_R,  0, 0, 0, C_NONE,  0);
    step("h_r_exec",     0, I_R,  0, 0, 0, C_EXR,   0);
    step("h_r_wb",       0, I_R,  0, 0, 0, C_WBR,   1);

    step("ill_fetch",  0, I_BAD, 1, 0, 0, C_FOK,  0);
    step("ill_decode", 0, I_BAD, 0, 0, 0, C_NONE, 0);
    for (int i = 0; i < 10; i++) step("ill_trap_sticky", 0, I_R, 1, 1, 1, C_T1, 0);
    step("ill_rst", 1, I_R, 0, 0, 0, C_NONE, 0);

    for (int i = 0; i < 16; i++) step("imem_wait", 0, I_R, 0, 0, 0, C_FWAIT, 0);
    for (int i = 0; i < 3; i++) step("imem_trap", 0, I_R, 1, 0, 0, C_T2, 0);
    step("imem_rst", 1, I_R, 0, 0, 0, C_NONE, 0);

    for (int i = 0; i < 15; i++) step("edge_wait", 0, I_R, 0, 0, 0, C_FWAIT, 0);
    step("edge_ready",  0, I_R, 1, 0, 0, C_FOK,  0);
    step("edge_decode", 0, I_R, 0, 0, 0, C_NONE, 0);
    step("edge_exec",   0, I_R, 0, 0, 0, C_EXR,  0);
    step("edge_wb",     0, I_R, 0, 0, 0, C_WBR,  1);

    step("dto_fetch",  0, I_LD, 1, 0, 0, C_FOK,  0);
    step("dto_decode", 0, I_LD, 0, 0, 0, C_NONE, 0);
    step("dto_exec",   0, I_LD, 0, 0, 0, C_EXLS, 0);
    for (int i = 0; i < 16; i++) step("dto_wait", 0, I_LD, 0, 0, 0, C_MEMRD, 0);
    for (int i = 0; i < 2; i++) step("dto_trap", 0, I_LD, 0, 1, 0, C_T3, 0);
    step("dto_rst", 1, I_LD, 0, 0, 0, C_NONE, 0);

    step("mr_fetch",  0, I_ST, 1, 0, 0, C_FOK,   0);
    step("mr_decode", 0, I_ST, 0, 0, 0, C_NONE,  0);
    step("mr_exec",   0, I_ST, 0, 0, 0, C_EXLS,  0);
    step("mr_mem",    0, I_ST, 0, 0, 0, C_MEMWR, 0);
    step("mr_rst",    1, I_ST, 0, 1, 1, C_NONE,  0);
    step("mr_after",  0, I_ST, 0, 0, 0, C_FWAIT, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM that sequences the RISC-V datapath (PC, instruction memory, register file, ALU, data memory) over multiple cycles instead of single-cycle combinational control.
- Replaces `control` as the source of branch/mem_read/mem_reg/ALU_op/mem_write/alu_src/reg_write.
- Adds PC/IR write enables and ready/request handshakes to instruction and data memory.
- Provides halt, trap and performance counters.

Parameters:
- CNT_W, 32, width of the cycle and retired-instruction counters.
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ready before a trap is raised; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instruction  in  32  current instruction word, valid when imem_ready=1 in FETCH.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- halt_req  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction into the IR.
- pc_write  out  1  unconditional PC update (PC+4).
- branch  out  1  conditional PC update; the PC mux is taken when branch & zero.
- mem_read  out  1  data memory read.
- mem_write  out  1  data memory write.
- mem_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- alu_src  out  1  ALU operand 2 select: 1 = immediate.
- reg_write  out  1  register file write enable.
- ALU_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- halted  out  1  FSM is in HALT.
- trap  out  1  FSM is in TRAP (sticky).
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.
- cycle_count  out  CNT_W  cycles since reset.
- instret_count  out  CNT_W  retired instructions.

Behaviour:
- **Reset.**
  - rst high on a clock edge → state FETCH, opcode register 0, wait counter 0, trap_cause 0, both counters 0.
  - While rst is high, every command output is forced to 0, and halted and trap are 0.
- **States.** FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. The encoding lives in the package.
- **Output timing.** Outputs decode combinationally from the state and the latched opcode. The only exception is in FETCH: ir_write and pc_write equal imem_ready (Mealy).
- **FETCH.**
  - If halt_req=1 on entry, go to HALT without asserting imem_req.
  - Otherwise imem_req=1. When imem_ready=1: ir_write=1, pc_write=1, latch instruction[6:0] as the opcode, go to DECODE.
- **DECODE.** Opcode must be one of 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (branch).
  - Any other opcode → TRAP, cause 1.
  - Legal opcode → EXEC.
- **EXEC, by opcode.**
  - R: ALU_op=10, alu_src=0 → WB.
  - I-ALU: ALU_op=10, alu_src=1 → WB.
  - Load/store: ALU_op=00, alu_src=1 → MEM.
  - Branch: ALU_op=01, alu_src=0, branch=1 → FETCH, and the instruction retires.
- **MEM.** ALU_op=00 and alu_src=1 are held throughout.
  - Load: mem_read=1 until dmem_ready, then → WB.
  - Store: mem_write=1 until dmem_ready, then → FETCH and retire.
- **WB.** reg_write=1, mem_reg=1 for load and 0 otherwise, ALU_op/alu_src held from EXEC → FETCH and retire.
- **Wait counter.**
  - Clears on entry to FETCH and on entry to MEM.
  - Increments each cycle that imem_req/mem_read/mem_write is high and ready is low.
  - Reaching MEM_TIMEOUT → TRAP, cause 2 (FETCH) or 3 (MEM).
  - Ready arriving in the same cycle the count reaches the limit wins: no trap.
- **HALT.** No commands. Return to FETCH when halt_req=0. halt_req is ignored outside FETCH and HALT, so an in-flight instruction always completes.
- **TRAP.** No commands. The state is left only by rst.
- **Latency with zero-wait memory.** R/I-ALU 4 cycles, load 5, store 4, branch 3.
- **Counters.**
  - cycle_count increments every non-reset cycle, including in HALT and TRAP.
  - instret_count increments on the retire edge.
  - Both wrap modulo 2^CNT_W with no saturation.
- **Mid-operation reset.** rst in any state (including MEM with a request pending) aborts the instruction without retiring it and drops all requests in that same cycle.

Decomposition:
- Package `multicycle_pkg`:
  - state enum
  - opcode constants
  - ALU_op encodings
  - trap_cause codes
- Natural sub-module `perf_counters`: the two CNT_W counters, with inputs clk, rst, retire.

Test Plan:
- Reset, then R-type 0x002081B3 with imem_ready tied 1 → imem_req high cycle 1; ALU_op=10, alu_src=0 in EXEC; reg_write=1, mem_reg=0 in cycle 4; instret_count=1 after 4 cycles.
- Load 0x00803283, dmem_ready delayed 3 cycles → mem_read high for 4 cycles; WB with mem_reg=1, reg_write=1; 8 cycles total.
- Store 0x00503823 then beq 0x00000063 → mem_write=1 only in MEM; branch=1, ALU_op=01 only in the branch's EXEC; instret_count=2 after 7 cycles.
- Opcode 0x0000007F → TRAP after DECODE, trap_cause=1, trap sticky across 10 cycles, cleared by rst; cycle_count keeps counting while trapped.
- imem_ready held 0 with MEM_TIMEOUT=16 → trap_cause=2 after 16 wait cycles. Repeat with ready asserted on the 16th cycle → no trap, DECODE entered.
- halt_req asserted mid-load → load completes and retires, then halted=1 with imem_req=0. Deassert halt_req → fetch resumes the next cycle.
